// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int unsigned STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_t;

  localparam int unsigned STALL_PC     = 0;
  localparam int unsigned STALL_IF_ID  = 1;
  localparam int unsigned STALL_ID_EX  = 2;
  localparam int unsigned STALL_EX_MEM = 3;
  localparam int unsigned STALL_WB     = 4;

  localparam stall_t STALL_MEM = 6'b011111;
  localparam stall_t STALL_EX  = 6'b001111;
  localparam stall_t STALL_ID  = 6'b000011;

  // A multi-cycle op only stalls when its result is not already available.
  function automatic logic mc_pending(input logic start, input logic done);
    return start & ~done;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Saturating stall-cycle / flush-count pair for pipeline_hazard_ctrl.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             stall_ev,
  input  logic             flush_ev,
  output logic [CNT_W-1:0] stall_cyc,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc <= '0;
      flush_cnt <= '0;
    end else if (clr) begin
      stall_cyc <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cyc != '1)) stall_cyc <= stall_cyc + 1'b1;
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with multi-cycle watchdog.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_load_use,
  input  logic               id_branch_taken,
  input  logic               ex_mc_start,
  input  logic               ex_mc_done,
  input  logic               mem_busy,
  output logic [STALL_W-1:0] stall,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               mc_timeout,
  output logic               busy
`ifdef HAZARD_PERF_CNT_EN
  , input  logic             perf_clr,
  output logic [CNT_W-1:0]   perf_stall_cyc,
  output logic [CNT_W-1:0]   perf_flush_cnt
`endif
);

  localparam int unsigned WD_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_cnt;
  stall_t          stall_c;
  logic            flush_if_id_c;
  logic            flush_id_ex_c;
  logic            timeout_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      // Held across a memory stall so MC_WAIT resumes where it left off.
      if (state_q == RUN)
        wd_cnt <= '0;
      else if ((state_q == MC_WAIT) && (wd_cnt != WD_LAST))
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_c       = '0;
    flush_id_ex_c = 1'b0;
    timeout_c     = 1'b0;
    if (mem_busy) begin
      stall_c = STALL_MEM;
      state_d = MEM_WAIT;
    end else if (state_q == MC_WAIT) begin
      if (ex_mc_done) begin
        state_d = RUN;
      end else if (wd_cnt == WD_LAST) begin
        timeout_c     = 1'b1;
        flush_id_ex_c = 1'b1;
        state_d       = RUN;
      end else begin
        stall_c = STALL_EX;
      end
    end else begin
      // RUN, or MEM_WAIT on the cycle memory releases: both resolve like RUN.
      state_d = RUN;
      if (mc_pending(ex_mc_start, ex_mc_done)) begin
        stall_c = STALL_EX;
        state_d = MC_WAIT;
      end else if (id_load_use) begin
        stall_c       = STALL_ID;
        flush_id_ex_c = 1'b1;
      end
    end
    flush_if_id_c = id_branch_taken & ~stall_c[STALL_IF_ID];
  end

  always_comb begin
    stall       = '0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    mc_timeout  = 1'b0;
    if (rst) begin
      stall       = stall_c;
      flush_if_id = flush_if_id_c;
      flush_id_ex = flush_id_ex_c;
      mc_timeout  = timeout_c;
    end
  end

  assign busy = (state_q != RUN);

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk      (clk),
    .rst      (rst),
    .clr      (perf_clr),
    .stall_ev (stall[STALL_PC]),
    .flush_ev (flush_if_id),
    .stall_cyc(perf_stall_cyc),
    .flush_cnt(perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MC_TIMEOUT = 8).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_load_use, id_branch_taken, ex_mc_start, ex_mc_done, mem_busy;
  logic [5:0] stall;
  logic       flush_if_id, flush_id_ex, mc_timeout, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MC_TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_load_use    (id_load_use),
    .id_branch_taken(id_branch_taken),
    .ex_mc_start    (ex_mc_start),
    .ex_mc_done     (ex_mc_done),
    .mem_busy       (mem_busy),
    .stall          (stall),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .mc_timeout     (mc_timeout),
    .busy           (busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_clr      (perf_clr),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mb, ms, md, lu, br;
    logic [5:0] stall;
    logic       fif, fie, busy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic mb, input logic ms, input logic md,
                        input logic lu, input logic br);
    mem_busy        = mb;
    ex_mc_start     = ms;
    ex_mc_done      = md;
    id_load_use     = lu;
    id_branch_taken = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000011, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001111, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b001111, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b011111, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000011, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 6'b0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", mc_timeout, 0);
    chk("rst_fif", flush_if_id, 0);
    chk("rst_fie", flush_id_ex, 0);
    rst = 1'b1;
    step();

    // Single-cycle decode from RUN, then the state reached at the edge
    for (int i = 0; i < 12; i++) begin
      do_reset();
      set_in(vecs[i].mb, vecs[i].ms, vecs[i].md, vecs[i].lu, vecs[i].br);
      #1;
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].stall);
      chk($sformatf("vec%0d_fif", i), flush_if_id, vecs[i].fif);
      chk($sformatf("vec%0d_fie", i), flush_id_ex, vecs[i].fie);
      chk($sformatf("vec%0d_to", i), mc_timeout, 0);
      step();
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // Load-use: exactly one bubble
    do_reset();
    set_in(0, 0, 0, 1, 0);
    #1;
    chk("lu_stall", stall, 6'b000011);
    chk("lu_fie", flush_id_ex, 1);
    step();
    set_in(0, 0, 0, 0, 0);
    #1;
    chk("lu_after_stall", stall, 6'b0);
    chk("lu_after_fie", flush_id_ex, 0);
    chk("lu_after_busy", busy, 0);

    // Five-cycle op: done pulsed in cycle 5
    do_reset();
    set_in(0, 1, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("mc5_c%0d_stall", c), stall, 6'b001111);
      chk($sformatf("mc5_c%0d_busy", c), busy, (c > 1) ? 1 : 0);
      step();
    end
    set_in(0, 1, 1, 0, 0);
    #1;
    chk("mc5_done_stall", stall, 6'b0);
    chk("mc5_done_busy", busy, 1);
    step();
    set_in(0, 0, 0, 0, 0);
    #1;
    chk("mc5_after_busy", busy, 0);
    chk("mc5_after_stall", stall, 6'b0);

    // Watchdog: done never arrives, pulse in the 8th MC_WAIT cycle
    do_reset();
    set_in(0, 1, 0, 0, 0);
    #1;
    chk("wd_run_stall", stall, 6'b001111);
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wd_k%0d_pulse", k), mc_timeout, (k == 8) ? 1 : 0);
      chk($sformatf("wd_k%0d_stall", k), stall, (k == 8) ? 6'b0 : 6'b001111);
      chk($sformatf("wd_k%0d_fie", k), flush_id_ex, (k == 8) ? 1 : 0);
      if (k < 8) step();
    end
    step();
    set_in(0, 0, 0, 0, 0);
    #1;
    chk("wd_after_busy", busy, 0);
    chk("wd_after_pulse", mc_timeout, 0);
    chk("wd_after_stall", stall, 6'b0);

    // Memory stall inside MC_WAIT with a taken branch waiting in ID
    do_reset();
    set_in(0, 1, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw_pre%0d_stall", c), stall, 6'b001111);
      chk($sformatf("mw_pre%0d_fif", c), flush_if_id, 0);
      step();
    end
    set_in(1, 1, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw_mem%0d_stall", c), stall, 6'b011111);
      chk($sformatf("mw_mem%0d_fif", c), flush_if_id, 0);
      chk($sformatf("mw_mem%0d_fie", c), flush_id_ex, 0);
      step();
    end
    set_in(0, 1, 0, 0, 1);
    #1;
    chk("mw_rel_stall", stall, 6'b001111);
    chk("mw_rel_busy", busy, 1);
    chk("mw_rel_fif", flush_if_id, 0);
    step();
    chk("mw_resume_stall", stall, 6'b001111);
    chk("mw_resume_busy", busy, 1);
    step();
    set_in(0, 1, 1, 0, 1);
    #1;
    chk("mw_done_stall", stall, 6'b0);
    chk("mw_done_fif", flush_if_id, 1);

    // Asynchronous reset in the middle of MC_WAIT and MEM_WAIT
    do_reset();
    set_in(0, 1, 0, 0, 1);
    repeat (4) step();
    chk("rmc_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("rmc_stall", stall, 6'b0);
    chk("rmc_busy", busy, 0);
    chk("rmc_fif", flush_if_id, 0);
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0);
    step();
    chk("rmem_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("rmem_stall", stall, 6'b0);
    chk("rmem_busy", busy, 0);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    step();

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    chk("perf_rst_stall", perf_stall_cyc, 0);
    chk("perf_rst_flush", perf_flush_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 1, 0);
      step();
      set_in(0, 0, 0, 0, 0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 1);
      step();
      set_in(0, 0, 0, 0, 0);
      step();
    end
    chk("perf_stall_cyc", perf_stall_cyc, 3);
    chk("perf_flush_cnt", perf_flush_cnt, 2);
    perf_clr = 1'b1;
    set_in(0, 0, 0, 1, 1);
    step();
    perf_clr = 1'b0;
    set_in(0, 0, 0, 0, 0);
    chk("perf_clr_stall", perf_stall_cyc, 0);
    chk("perf_clr_flush", perf_flush_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
